// File: rtl/esdi_drive_responder.sv
`default_nettype none
// ============================================================================
// Module  : esdi_drive_responder
// Brief   : Drive-side ESDI serial command / config-status responder.
//           Receives 17-bit odd-parity command frames over a req/ack
//           handshake, hands them to local logic, and returns an odd-parity
//           config/status word for status/config requests.
// Revision: 1.0 - initial release
// ============================================================================
module esdi_drive_responder #(
  parameter int SYNC_STAGES  = 2,
  parameter int RESP_TIMEOUT = 1023
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        esdi_transfer_req,
  input  logic        esdi_command_data,
  output logic        esdi_transfer_ack,
  output logic        esdi_confstat_data,
  output logic        esdi_command_complete,
  output logic        esdi_attention,
  output logic [15:0] cmd_word,
  output logic        cmd_valid,
  input  logic [15:0] resp_word,
  input  logic        resp_valid,
  input  logic        resp_error
);

  // Timer counts 0 .. RESP_TIMEOUT-1 while waiting in EXEC.
  localparam int              TMR_W    = (RESP_TIMEOUT < 2) ? 1 : $clog2(RESP_TIMEOUT);
  localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(RESP_TIMEOUT - 1);
  localparam logic [4:0]      FRAME_BITS = 5'd17;
  localparam logic [4:0]      LAST_STS   = 5'd16;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_CMD_ACK  = 3'd1,
    ST_CMD_REL  = 3'd2,
    ST_EXEC     = 3'd3,
    ST_STS_WAIT = 3'd4,
    ST_STS_ACK  = 3'd5,
    ST_STS_REL  = 3'd6
  } state_t;

  state_t                 state_q, state_d;
  logic [SYNC_STAGES-1:0] req_sync_q, req_sync_d;
  logic [SYNC_STAGES-1:0] data_sync_q, data_sync_d;
  logic                   req_prev_q, req_prev_d;
  logic [4:0]             bit_cnt_q, bit_cnt_d;
  logic [16:0]            shreg_q, shreg_d;
  logic [TMR_W-1:0]       tmr_q, tmr_d;
  logic                   ack_q, ack_d;
  logic                   confstat_q, confstat_d;
  logic                   complete_q, complete_d;
  logic                   attention_q, attention_d;
  logic [15:0]            cmd_word_q, cmd_word_d;
  logic                   cmd_valid_q, cmd_valid_d;

  logic                   req_s;
  logic                   data_s;
  logic                   req_rise;
  logic [3:0]             opcode;
  logic                   is_xfer_op;

  assign req_s      = req_sync_q[SYNC_STAGES-1];
  assign data_s     = data_sync_q[SYNC_STAGES-1];
  assign req_rise   = req_s & ~req_prev_q;
  assign opcode     = cmd_word_q[15:12];
  assign is_xfer_op = (opcode == 4'h2) || (opcode == 4'h3);

  // Shift the asynchronous host lines through the synchronizer chains.
  always_comb begin
    req_sync_d  = {req_sync_q[SYNC_STAGES-2:0], esdi_transfer_req};
    data_sync_d = {data_sync_q[SYNC_STAGES-2:0], esdi_command_data};
    req_prev_d  = req_s;
  end

  // Next-state and output logic for the handshake / execution sequencer.
  always_comb begin
    state_d     = state_q;
    bit_cnt_d   = bit_cnt_q;
    shreg_d     = shreg_q;
    tmr_d       = tmr_q;
    ack_d       = ack_q;
    confstat_d  = confstat_q;
    complete_d  = complete_q;
    attention_d = attention_q;
    cmd_word_d  = cmd_word_q;
    cmd_valid_d = 1'b0;

    case (state_q)
      ST_IDLE, ST_CMD_REL: begin
        if (req_rise) begin
          shreg_d   = {shreg_q[15:0], data_s};
          bit_cnt_d = bit_cnt_q + 5'd1;
          ack_d     = 1'b1;
          state_d   = ST_CMD_ACK;
          // Busy is signalled together with the first ack of a frame.
          if (bit_cnt_q == 5'd0) begin
            complete_d = 1'b0;
          end
        end
      end

      ST_CMD_ACK: begin
        if (!req_s) begin
          ack_d = 1'b0;
          if (bit_cnt_q == FRAME_BITS) begin
            bit_cnt_d = 5'd0;
            if (^shreg_q) begin
              cmd_word_d  = shreg_q[16:1];
              cmd_valid_d = 1'b1;
              attention_d = 1'b0;
              tmr_d       = '0;
              state_d     = ST_EXEC;
            end else begin
              attention_d = 1'b1;
              complete_d  = 1'b1;
              state_d     = ST_IDLE;
            end
          end else begin
            state_d = ST_CMD_REL;
          end
        end
      end

      ST_EXEC: begin
        // A response arriving on the terminal count takes priority.
        if (resp_valid) begin
          tmr_d = '0;
          if (resp_error) begin
            attention_d = 1'b1;
          end
          if (is_xfer_op && !resp_error) begin
            shreg_d   = {resp_word, ~^resp_word};
            bit_cnt_d = 5'd0;
            state_d   = ST_STS_WAIT;
          end else begin
            complete_d = 1'b1;
            state_d    = ST_IDLE;
          end
        end else if (tmr_q == TMR_LAST) begin
          tmr_d       = '0;
          attention_d = 1'b1;
          complete_d  = 1'b1;
          state_d     = ST_IDLE;
        end else begin
          tmr_d = tmr_q + 1'b1;
        end
      end

      ST_STS_WAIT: begin
        // Present the bit now; ack follows one clock later.
        if (req_rise) begin
          confstat_d = shreg_q[16];
          state_d    = ST_STS_ACK;
        end
      end

      ST_STS_ACK: begin
        if (!ack_q) begin
          ack_d = 1'b1;
        end else if (!req_s) begin
          ack_d   = 1'b0;
          state_d = ST_STS_REL;
        end
      end

      ST_STS_REL: begin
        shreg_d = {shreg_q[15:0], 1'b0};
        if (bit_cnt_q == LAST_STS) begin
          bit_cnt_d  = 5'd0;
          confstat_d = 1'b0;
          complete_d = 1'b1;
          state_d    = ST_IDLE;
        end else begin
          bit_cnt_d = bit_cnt_q + 5'd1;
          state_d   = ST_STS_WAIT;
        end
      end

      default: begin
        bit_cnt_d  = 5'd0;
        ack_d      = 1'b0;
        confstat_d = 1'b0;
        complete_d = 1'b1;
        state_d    = ST_IDLE;
      end
    endcase
  end

  // State, datapath and synchronizer registers with asynchronous reset.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q     <= ST_IDLE;
      req_sync_q  <= '0;
      data_sync_q <= '0;
      req_prev_q  <= 1'b0;
      bit_cnt_q   <= 5'd0;
      shreg_q     <= 17'd0;
      tmr_q       <= '0;
      ack_q       <= 1'b0;
      confstat_q  <= 1'b0;
      complete_q  <= 1'b1;
      attention_q <= 1'b0;
      cmd_word_q  <= 16'h0000;
      cmd_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      req_sync_q  <= req_sync_d;
      data_sync_q <= data_sync_d;
      req_prev_q  <= req_prev_d;
      bit_cnt_q   <= bit_cnt_d;
      shreg_q     <= shreg_d;
      tmr_q       <= tmr_d;
      ack_q       <= ack_d;
      confstat_q  <= confstat_d;
      complete_q  <= complete_d;
      attention_q <= attention_d;
      cmd_word_q  <= cmd_word_d;
      cmd_valid_q <= cmd_valid_d;
    end
  end

  assign esdi_transfer_ack     = ack_q;
  assign esdi_confstat_data    = confstat_q;
  assign esdi_command_complete = complete_q;
  assign esdi_attention        = attention_q;
  assign cmd_word              = cmd_word_q;
  assign cmd_valid             = cmd_valid_q;

endmodule
`default_nettype wire
